// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory / memory-mapped I/O controller: fixed-wait-state SRAM accesses
// and single-cycle accesses to the switch/hex register at IO_ADDR.
module lc3_mem_ctrl #(
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MEM_EN,
  input  logic        WE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic [15:0] SW,
  input  logic [15:0] SRAM_RDATA,
  output logic [15:0] MDR_In,
  output logic        R,
  output logic [15:0] HEX_Out,
  output logic [15:0] SRAM_ADDR,
  output logic [15:0] SRAM_WDATA,
  output logic        SRAM_DQ_OE,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                we_q;
  logic                r_q;
  logic [DATA_W-1:0]   mdr_in_q;
  logic [DATA_W-1:0]   hex_q;
  logic [DATA_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                dq_oe_q;
  logic                ce_n_q;
  logic                oe_n_q;
  logic                we_n_q;
  logic                io_hit;

  assign io_hit = (MAR == IO_ADDR);

  // Access sequencer; every output comes straight from a register below.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      r_q      <= 1'b0;
      mdr_in_q <= '0;
      hex_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      dq_oe_q  <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
    end else begin
      r_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (MEM_EN) begin
            we_q    <= WE;
            wdata_q <= MDR;
            if (io_hit) begin
              state_q <= DONE;
              r_q     <= 1'b1;
              if (WE) begin
                hex_q <= MDR;
              end else begin
                mdr_in_q <= SW;
              end
            end else begin
              state_q <= ACCESS;
              addr_q  <= MAR;
              cnt_q   <= CNT_W'(WAIT_STATES);
              ce_n_q  <= 1'b0;
              if (WE) begin
                we_n_q  <= 1'b0;
                dq_oe_q <= 1'b1;
              end else begin
                oe_n_q <= 1'b0;
              end
            end
          end
        end
        ACCESS: begin
          // Strobes, address and data stay put until the wait count expires.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            if (!we_q) begin
              mdr_in_q <= SRAM_RDATA;
            end
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            r_q     <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign MDR_In     = mdr_in_q;
  assign R          = r_q;
  assign HEX_Out    = hex_q;
  assign SRAM_ADDR  = addr_q;
  assign SRAM_WDATA = wdata_q;
  assign SRAM_DQ_OE = dq_oe_q;
  assign SRAM_CE_N  = ce_n_q;
  assign SRAM_OE_N  = oe_n_q;
  assign SRAM_WE_N  = we_n_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed self-checking bench for lc3_mem_ctrl with WAIT_STATES=2.
module tb_lc3_mem_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        MEM_EN;
  logic        WE;
  logic [15:0] MAR;
  logic [15:0] MDR;
  logic [15:0] SW;
  logic [15:0] SRAM_RDATA;
  logic [15:0] MDR_In;
  logic        R;
  logic [15:0] HEX_Out;
  logic [15:0] SRAM_ADDR;
  logic [15:0] SRAM_WDATA;
  logic        SRAM_DQ_OE;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;
  logic        SRAM_WE_N;

  int checks = 0;
  int errors = 0;

  lc3_mem_ctrl #(.WAIT_STATES(2), .IO_ADDR(16'hFFFF)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .MEM_EN     (MEM_EN),
    .WE         (WE),
    .MAR        (MAR),
    .MDR        (MDR),
    .SW         (SW),
    .SRAM_RDATA (SRAM_RDATA),
    .MDR_In     (MDR_In),
    .R          (R),
    .HEX_Out    (HEX_Out),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_WDATA (SRAM_WDATA),
    .SRAM_DQ_OE (SRAM_DQ_OE),
    .SRAM_CE_N  (SRAM_CE_N),
    .SRAM_OE_N  (SRAM_OE_N),
    .SRAM_WE_N  (SRAM_WE_N)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_strobes(input string tag, input logic ce_n, input logic oe_n,
                               input logic we_n, input logic dq_oe);
    check({tag, ".ce_n"},  16'(SRAM_CE_N),  16'(ce_n));
    check({tag, ".oe_n"},  16'(SRAM_OE_N),  16'(oe_n));
    check({tag, ".we_n"},  16'(SRAM_WE_N),  16'(we_n));
    check({tag, ".dq_oe"}, 16'(SRAM_DQ_OE), 16'(dq_oe));
  endtask

  initial begin
    Reset = 1'b1; MEM_EN = 1'b0; WE = 1'b0;
    MAR = '0; MDR = '0; SW = '0; SRAM_RDATA = '0;
    tick();
    tick();
    check("rst.r", 16'(R), 16'h0);
    check("rst.mdr_in", MDR_In, 16'h0000);
    check("rst.hex", HEX_Out, 16'h0000);
    check("rst.addr", SRAM_ADDR, 16'h0000);
    check("rst.wdata", SRAM_WDATA, 16'h0000);
    check_strobes("rst", 1'b1, 1'b1, 1'b1, 1'b0);

    // SRAM read with MAR changed mid-flight
    Reset = 1'b0;
    MAR = 16'h0040; WE = 1'b0; MEM_EN = 1'b1; SRAM_RDATA = 16'h1234;
    tick();
    MEM_EN = 1'b0; MAR = 16'h0FFF;
    for (int i = 0; i < 3; i++) begin
      check_strobes("rd.acc", 1'b0, 1'b0, 1'b1, 1'b0);
      check("rd.addr", SRAM_ADDR, 16'h0040);
      check("rd.r_low", 16'(R), 16'h0);
      tick();
    end
    check("rd.r", 16'(R), 16'h1);
    check("rd.mdr_in", MDR_In, 16'h1234);
    check_strobes("rd.done", 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    check("rd.r_off", 16'(R), 16'h0);
    check("rd.mdr_hold", MDR_In, 16'h1234);

    // SRAM write
    MAR = 16'h0100; MDR = 16'hBEEF; WE = 1'b1; MEM_EN = 1'b1;
    tick();
    MEM_EN = 1'b0; MDR = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      check_strobes("wr.acc", 1'b0, 1'b1, 1'b0, 1'b1);
      check("wr.wdata", SRAM_WDATA, 16'hBEEF);
      check("wr.addr", SRAM_ADDR, 16'h0100);
      tick();
    end
    check("wr.r", 16'(R), 16'h1);
    check("wr.mdr_in_kept", MDR_In, 16'h1234);
    check_strobes("wr.done", 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    check("wr.r_off", 16'(R), 16'h0);

    // I/O write then I/O read
    MAR = 16'hFFFF; MDR = 16'h00A5; WE = 1'b1; MEM_EN = 1'b1;
    tick();
    MEM_EN = 1'b0;
    check("iow.r", 16'(R), 16'h1);
    check("iow.hex", HEX_Out, 16'h00A5);
    check_strobes("iow", 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    check("iow.r_off", 16'(R), 16'h0);
    MAR = 16'hFFFF; WE = 1'b0; SW = 16'h3C3C; MEM_EN = 1'b1;
    tick();
    MEM_EN = 1'b0;
    check("ior.r", 16'(R), 16'h1);
    check("ior.mdr_in", MDR_In, 16'h3C3C);
    check("ior.hex_kept", HEX_Out, 16'h00A5);
    check_strobes("ior", 1'b1, 1'b1, 1'b1, 1'b0);
    tick();

    // Back-to-back reads with MEM_EN held
    MAR = 16'h0001; WE = 1'b0; SRAM_RDATA = 16'h1111; MEM_EN = 1'b1;
    tick();
    MAR = 16'h0002;
    check("b2b.addr1", SRAM_ADDR, 16'h0001);
    tick();
    tick();
    tick();
    check("b2b.r1", 16'(R), 16'h1);
    check("b2b.mdr1", MDR_In, 16'h1111);
    SRAM_RDATA = 16'h2222;
    tick();
    check("b2b.idle_r", 16'(R), 16'h0);
    check("b2b.idle_ce", 16'(SRAM_CE_N), 16'h1);
    tick();
    MEM_EN = 1'b0;
    check("b2b.addr2", SRAM_ADDR, 16'h0002);
    check("b2b.ce2", 16'(SRAM_CE_N), 16'h0);
    check("b2b.mdr_mid", MDR_In, 16'h1111);
    tick();
    tick();
    tick();
    check("b2b.r2", 16'(R), 16'h1);
    check("b2b.mdr2", MDR_In, 16'h2222);
    tick();

    // Reset during second ACCESS cycle
    MAR = 16'h0200; WE = 1'b0; SRAM_RDATA = 16'h5555; MEM_EN = 1'b1;
    tick();
    MEM_EN = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("rstmid.r", 16'(R), 16'h0);
    check("rstmid.mdr_in", MDR_In, 16'h0000);
    check("rstmid.hex", HEX_Out, 16'h0000);
    check_strobes("rstmid", 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rstmid.no_r", 16'(R), 16'h0);
      check("rstmid.mdr_still0", MDR_In, 16'h0000);
    end

    // Reset wins over a simultaneous request
    Reset = 1'b1; MEM_EN = 1'b1; MAR = 16'h0300;
    tick();
    Reset = 1'b0; MEM_EN = 1'b0;
    check("rstreq.ce", 16'(SRAM_CE_N), 16'h1);
    tick();
    check("rstreq.ce_after", 16'(SRAM_CE_N), 16'h1);
    check("rstreq.r", 16'(R), 16'h0);
    check("rstreq.addr", SRAM_ADDR, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
